// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I-cache and D-cache miss traffic.
// One transaction in flight at a time. D-cache has priority, but the I-cache is
// granted after MAX_D_STREAK consecutive D grants while it is waiting.
//
// Ports
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   ic_rd_i, ic_addr_i                  I-cache read request (held until ic_done_o)
//   ic_data_o, ic_done_o, ic_stall_o    I-cache read data, completion pulse, stall
//   dc_rd_i, dc_wr_i, dc_addr_i,
//   dc_data_i                           D-cache request (held until dc_done_o)
//   dc_data_o, dc_done_o, dc_stall_o    D-cache read data, completion pulse, stall
//   mem_rd_o, mem_wr_o, mem_addr_o,
//   mem_data_o                          memory strobes with latched address/data
//   mem_stall_i, mem_done_i, mem_data_i memory handshake and read data
//   ic_grant_cnt_o, dc_grant_cnt_o      wrapping grant counters
//   proto_err_o                         sticky: mem_done_i seen outside the wait state
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_rd_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic [DATA_W-1:0] ic_data_o,
    output logic              ic_done_o,
    output logic              ic_stall_o,
    input  logic              dc_rd_i,
    input  logic              dc_wr_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [DATA_W-1:0] dc_data_i,
    output logic [DATA_W-1:0] dc_data_o,
    output logic              dc_done_o,
    output logic              dc_stall_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_stall_i,
    input  logic              mem_done_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [CNT_W-1:0]  ic_grant_cnt_o,
    output logic [CNT_W-1:0]  dc_grant_cnt_o,
    output logic              proto_err_o
);

    localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q;
    logic                owner_i_q;  // 1: I-cache owns the transaction, 0: D-cache
    logic                op_wr_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_data_q;
    logic [DATA_W-1:0]   ic_data_q;
    logic [DATA_W-1:0]   dc_data_q;
    logic                ic_done_q;
    logic                dc_done_q;
    logic [CNT_W-1:0]    ic_cnt_q;
    logic [CNT_W-1:0]    dc_cnt_q;
    logic [StreakW-1:0]  streak_q;
    logic                proto_err_q;

    logic dc_req;
    logic any_req;
    logic pick_i;

    always_comb begin
        dc_req  = dc_rd_i | dc_wr_i;
        any_req = ic_rd_i | dc_req;
        // I wins when it is alone, or when D has used up its streak allowance.
        pick_i  = ic_rd_i & (~dc_req | (streak_q == StreakMax));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_i_q   <= 1'b0;
            op_wr_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            ic_data_q   <= '0;
            dc_data_q   <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            ic_cnt_q    <= '0;
            dc_cnt_q    <= '0;
            streak_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;

            if (mem_done_i && (state_q != StWait)) begin
                proto_err_q <= 1'b1;
            end

            // Streak only counts D grants that actually made the I-cache wait.
            if (!ic_rd_i) begin
                streak_q <= '0;
            end else if ((state_q == StIdle) && any_req) begin
                if (pick_i) begin
                    streak_q <= '0;
                end else begin
                    streak_q <= streak_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_i_q <= pick_i;
                        if (pick_i) begin
                            op_wr_q    <= 1'b0;
                            mem_rd_q   <= 1'b1;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= ic_addr_i;
                            ic_cnt_q   <= ic_cnt_q + 1'b1;
                        end else begin
                            // Read and write together is treated as a write.
                            op_wr_q    <= dc_wr_i;
                            mem_rd_q   <= ~dc_wr_i;
                            mem_wr_q   <= dc_wr_i;
                            mem_addr_q <= dc_addr_i;
                            mem_data_q <= dc_data_i;
                            dc_cnt_q   <= dc_cnt_q + 1'b1;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!mem_stall_i) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (mem_done_i) begin
                        if (owner_i_q) begin
                            ic_done_q <= 1'b1;
                            if (!op_wr_q) begin
                                ic_data_q <= mem_data_i;
                            end
                        end else begin
                            dc_done_q <= 1'b1;
                            if (!op_wr_q) begin
                                dc_data_q <= mem_data_i;
                            end
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Owner drops its request here; nothing is sampled this cycle.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ic_data_o      = ic_data_q;
    assign ic_done_o      = ic_done_q;
    assign dc_data_o      = dc_data_q;
    assign dc_done_o      = dc_done_q;
    assign mem_rd_o       = mem_rd_q;
    assign mem_wr_o       = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign ic_grant_cnt_o = ic_cnt_q;
    assign dc_grant_cnt_o = dc_cnt_q;
    assign proto_err_o    = proto_err_q;

    // Stalls are combinational so the cache sees them in the request cycle.
    assign ic_stall_o = ic_rd_i & ~ic_done_q;
    assign dc_stall_o = dc_req & ~dc_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXS = 4;
    localparam int unsigned CW   = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ic_rd_i;
    logic [AW-1:0] ic_addr_i;
    logic [DW-1:0] ic_data_o;
    logic          ic_done_o;
    logic          ic_stall_o;
    logic          dc_rd_i;
    logic          dc_wr_i;
    logic [AW-1:0] dc_addr_i;
    logic [DW-1:0] dc_data_i;
    logic [DW-1:0] dc_data_o;
    logic          dc_done_o;
    logic          dc_stall_o;
    logic          mem_rd_o;
    logic          mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_stall_i;
    logic          mem_done_i;
    logic [DW-1:0] mem_data_i;
    logic [CW-1:0] ic_grant_cnt_o;
    logic [CW-1:0] dc_grant_cnt_o;
    logic          proto_err_o;

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_D_STREAK(MAXS),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ic_rd_i(ic_rd_i),
        .ic_addr_i(ic_addr_i),
        .ic_data_o(ic_data_o),
        .ic_done_o(ic_done_o),
        .ic_stall_o(ic_stall_o),
        .dc_rd_i(dc_rd_i),
        .dc_wr_i(dc_wr_i),
        .dc_addr_i(dc_addr_i),
        .dc_data_i(dc_data_i),
        .dc_data_o(dc_data_o),
        .dc_done_o(dc_done_o),
        .dc_stall_o(dc_stall_o),
        .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_stall_i(mem_stall_i),
        .mem_done_i(mem_done_i),
        .mem_data_i(mem_data_i),
        .ic_grant_cnt_o(ic_grant_cnt_o),
        .dc_grant_cnt_o(dc_grant_cnt_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_i;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    typedef struct {
        bit          rst_first;
        logic [15:0] ic_addr;
        bit          dc_rd;
        bit          dc_wr;
        logic [15:0] dc_addr;
        logic [15:0] dc_data;
        int          i_n;
        int          d_n;
        int          stall_n;
        int          dly;
        int          exp_ic;
        int          exp_dc;
    } vec_t;

    op_t         exp_q[$];
    op_t         cur;
    logic [15:0] mem_m [logic [15:0]];
    vec_t        vecs [9];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int rs_st, rs_cnt, strobe_cnt, stall_n, dly;
    bit rsp_no_done;
    int i_left, d_left;
    logic [15:0] last_ic, last_dc, cur_rdata;
    int req_cyc, last_done_cyc;
    bit chk_lat, b2b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_peek(input logic [15:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 16'h5A5A;
    endfunction

    // One clock of memory responder + cache behaviour, sampled on the falling edge.
    task automatic step();
        @(negedge clk_i);
        cyc++;
        mem_done_i = 1'b0;
        if (rs_st != 3) chk("no_done", {30'd0, ic_done_o, dc_done_o}, 32'd0);
        case (rs_st)
            0: begin
                if (mem_rd_o | mem_wr_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_op", 0, 1);
                        cur = '{0, mem_wr_o, mem_addr_o, mem_data_o};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    chk("grant_addr", mem_addr_o, cur.addr);
                    chk("grant_op", {mem_rd_o, mem_wr_o}, {~cur.wr, cur.wr});
                    if (cur.wr) chk("grant_wdata", mem_data_o, cur.data);
                    chk("ic_stall", ic_stall_o, ic_rd_i);
                    chk("dc_stall", dc_stall_o, dc_rd_i | dc_wr_i);
                    if (chk_lat) begin
                        chk("issue_latency", cyc - req_cyc, 1);
                        chk_lat = 0;
                    end
                    if (b2b) begin
                        chk("b2b_gap", cyc - last_done_cyc, 2);
                        b2b = 0;
                    end
                    strobe_cnt = 1;
                    rs_cnt = 0;
                    if (stall_n > 0) begin
                        mem_stall_i = 1'b1;
                        rs_st = 1;
                    end else begin
                        rs_st = 2;
                    end
                end
            end
            1: begin
                if (mem_rd_o | mem_wr_o) strobe_cnt++;
                chk("issue_hold", {mem_rd_o, mem_wr_o, mem_addr_o}, {~cur.wr, cur.wr, cur.addr});
                if (cur.wr) chk("issue_wdata", mem_data_o, cur.data);
                rs_cnt++;
                if (rs_cnt == stall_n) begin
                    mem_stall_i = 1'b0;
                    rs_st = 2;
                    rs_cnt = 0;
                end
            end
            2: begin
                rs_cnt++;
                if (rs_cnt == 1) begin
                    chk("strobe_drop", {mem_rd_o, mem_wr_o}, 0);
                    chk("strobe_cycles", strobe_cnt, stall_n + 1);
                end
                if (rs_cnt >= dly && !rsp_no_done) begin
                    mem_done_i = 1'b1;
                    if (cur.wr) begin
                        mem_data_i = 16'hDEAD;
                        mem_m[cur.addr] = cur.data;
                    end else begin
                        cur_rdata = mem_peek(cur.addr);
                        mem_data_i = cur_rdata;
                    end
                    rs_st = 3;
                end
            end
            default: begin
                chk("done_pulse", {ic_done_o, dc_done_o}, {cur.is_i, ~cur.is_i});
                if (!cur.wr) begin
                    if (cur.is_i) last_ic = cur_rdata;
                    else last_dc = cur_rdata;
                end
                chk("ic_data", ic_data_o, last_ic);
                chk("dc_data", dc_data_o, last_dc);
                if (cur.is_i) chk("ic_stall_done", ic_stall_o, 0);
                else chk("dc_stall_done", dc_stall_o, 0);
                if (cur.is_i) begin
                    i_left--;
                    if (i_left == 0) ic_rd_i = 1'b0;
                end else begin
                    d_left--;
                    if (d_left == 0) begin
                        dc_rd_i = 1'b0;
                        dc_wr_i = 1'b0;
                    end
                end
                last_done_cyc = cyc;
                b2b = (i_left > 0) || (d_left > 0);
                rs_st = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ic_rd_i = 1'b0;
        dc_rd_i = 1'b0;
        dc_wr_i = 1'b0;
        mem_stall_i = 1'b0;
        mem_done_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rs_st = 0;
        exp_q.delete();
        last_ic = '0;
        last_dc = '0;
        i_left = 0;
        d_left = 0;
        b2b = 0;
        chk_lat = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int il, dl, s;
        if (v.rst_first) do_reset();
        // Reference arbitration order: D first, I after MAXS waiting D grants.
        il = v.i_n;
        dl = v.d_n;
        s = 0;
        while (il > 0 || dl > 0) begin
            if (dl > 0 && !(il > 0 && s == MAXS)) begin
                exp_q.push_back('{0, v.dc_wr, v.dc_addr, v.dc_data});
                dl--;
                if (il > 0) s++;
            end else begin
                exp_q.push_back('{1, 0, v.ic_addr, 16'h0000});
                il--;
                s = 0;
            end
        end
        stall_n = v.stall_n;
        dly = v.dly;
        i_left = v.i_n;
        d_left = v.d_n;
        ic_addr_i = v.ic_addr;
        ic_rd_i = (v.i_n > 0);
        dc_addr_i = v.dc_addr;
        dc_data_i = v.dc_data;
        dc_rd_i = (v.d_n > 0) && v.dc_rd;
        dc_wr_i = (v.d_n > 0) && v.dc_wr;
        req_cyc = cyc;
        chk_lat = 1;
        b2b = 0;
        for (int k = 0; k < 400 && (i_left > 0 || d_left > 0 || rs_st != 0); k++) step();
        chk("vec_complete", i_left + d_left, 0);
        step();
        step();
        chk("ic_cnt", ic_grant_cnt_o, v.exp_ic);
        chk("dc_cnt", dc_grant_cnt_o, v.exp_dc);
        chk("proto_err_clean", proto_err_o, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //         rst ic_addr   rd wr dc_addr   dc_data   i  d  st dly ic dc
        vecs[0] = '{1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 3, 1, 0};
        vecs[1] = '{1, 16'h0080, 1, 0, 16'h0200, 16'h0000, 1, 1, 0, 2, 1, 1};
        vecs[2] = '{0, 16'h0300, 1, 0, 16'h0400, 16'h0000, 1, 6, 0, 2, 2, 7};
        vecs[3] = '{0, 16'h0000, 0, 1, 16'h0100, 16'h1234, 0, 1, 5, 2, 2, 8};
        vecs[4] = '{0, 16'h0000, 1, 0, 16'h0100, 16'h0000, 0, 1, 1, 1, 2, 9};
        vecs[5] = '{0, 16'h0000, 1, 1, 16'h0500, 16'hCAFE, 0, 1, 0, 2, 2, 10};
        vecs[6] = '{0, 16'h0000, 1, 0, 16'h0500, 16'h0000, 0, 1, 2, 4, 2, 11};
        vecs[7] = '{0, 16'h0042, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 3, 11};
        vecs[8] = '{1, 16'h0600, 0, 0, 16'h0000, 16'h0000, 17, 0, 0, 1, 1, 0};

        mem_m[16'h0040] = 16'hBEEF;
        rsp_no_done = 0;
        ic_addr_i = '0;
        dc_addr_i = '0;
        dc_data_i = '0;
        mem_data_i = '0;
        stall_n = 0;
        dly = 1;
        cur_rdata = '0;

        // Reset state, held in reset and just after release.
        do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mem_strobes", {mem_rd_o, mem_wr_o}, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_dones", {ic_done_o, dc_done_o}, 0);
        chk("rst_data", {ic_data_o, dc_data_o}, 0);
        chk("rst_cnts", {ic_grant_cnt_o, dc_grant_cnt_o}, 0);
        chk("rst_proto_err", proto_err_o, 0);
        chk("rst_stalls", {ic_stall_o, dc_stall_o}, 0);
        rst_i = 1'b0;
        step();
        chk("idle_no_strobe", {mem_rd_o, mem_wr_o}, 0);

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Reset while waiting on memory; a late mem_done must be flagged, not delivered.
        do_reset();
        rsp_no_done = 1;
        stall_n = 0;
        dly = 1;
        exp_q.push_back('{1, 0, 16'h0700, 16'h0000});
        i_left = 1;
        ic_addr_i = 16'h0700;
        ic_rd_i = 1'b1;
        repeat (4) step();
        chk("wait_cnt_before_rst", ic_grant_cnt_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_strobes", {mem_rd_o, mem_wr_o}, 0);
        chk("mid_rst_addr", mem_addr_o, 0);
        chk("mid_rst_cnt", ic_grant_cnt_o, 0);
        chk("mid_rst_done", {ic_done_o, dc_done_o}, 0);
        ic_rd_i = 1'b0;
        i_left = 0;
        rs_st = 0;
        rsp_no_done = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        mem_data_i = 16'h1111;
        mem_done_i = 1'b1;
        @(negedge clk_i);
        mem_done_i = 1'b0;
        chk("late_done_proto_err", proto_err_o, 1);
        chk("late_done_no_pulse", {ic_done_o, dc_done_o}, 0);
        chk("late_done_no_capture", ic_data_o, 0);
        @(negedge clk_i);
        chk("proto_err_sticky", proto_err_o, 1);
        chk("late_done_idle", {mem_rd_o, mem_wr_o}, 0);
        do_reset();
        chk("proto_err_cleared", proto_err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
